warp_issue_scheduler: RTL and testbench

//  Shares one lane_array between NUM_WARPS instruction streams. It picks one pending warp round-robin.
//  It issues that warp's instruction and lane mask to the lane array as a single-cycle execute.
//  It waits for the array to finish, reports which warp completed, then grants the next warp.
//  A watchdog flags a lane array that never returns ready.

---
 rtl/warp_issue_scheduler.sv | 100 ++++++++++
 tb/tb_warp_issue_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_issue_scheduler.sv
// warp_issue_scheduler: round-robin issue of warp instructions to a shared lane array with a watchdog
module warp_issue_scheduler #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_LANES = 4,
  parameter int TIMEOUT = 32,
  localparam int WID = $clog2(NUM_WARPS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_WARPS-1:0]           warp_valid,
  input  logic [32*NUM_WARPS-1:0]        warp_inst,
  input  logic [NUM_LANES*NUM_WARPS-1:0] warp_mask,
  output logic [NUM_WARPS-1:0]           warp_ack,
  output logic                           la_execute,
  output logic [31:0]                    la_instruction,
  output logic [NUM_LANES-1:0]           la_lane_enable,
  input  logic                           la_ready,
  output logic                           done_valid,
  output logic [WID-1:0]                 done_warp,
  output logic                           timeout_err,
  output logic                           busy
);
  localparam int WD = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [WID-1:0] rr_q, rr_d, id_q, id_d, done_warp_q, done_warp_d, pick, cand;
  logic [WD-1:0] wdog_q, wdog_d;
  logic [31:0] inst_q, inst_d;
  logic [NUM_LANES-1:0] mask_q, mask_d, pick_mask;
  logic [NUM_WARPS-1:0] ack_q, ack_d;
  logic exec_q, exec_d, done_q, done_d, tmo_q, tmo_d;
  logic grant, fin_ok, fin_to, to_done;
  always_comb begin
    pick = '0;
    cand = '0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      cand = WID'((int'(rr_q) + i) % NUM_WARPS);
      pick = warp_valid[cand] ? cand : pick;
    end
    pick_mask = warp_mask[NUM_LANES*int'(pick) +: NUM_LANES];
  end
  always_comb begin
    grant = state_q == IDLE && |warp_valid;
    fin_ok = state_q == WAIT && wdog_q != WD'(1) && la_ready;
    fin_to = state_q == WAIT && !fin_ok && wdog_q == WD'(TIMEOUT);
    to_done = (state_q == ISSUE && !(|mask_q)) || fin_ok || fin_to;
    state_d = state_q;
    case (state_q)
      IDLE: state_d = grant ? ISSUE : IDLE;
      ISSUE: state_d = |mask_q ? WAIT : DONE;
      WAIT: state_d = fin_ok || fin_to ? DONE : WAIT;
      default: state_d = IDLE;
    endcase
    id_d = grant ? pick : id_q;
    inst_d = grant ? warp_inst[32*int'(pick) +: 32] : inst_q;
    mask_d = grant ? pick_mask : mask_q;
    ack_d = grant ? NUM_WARPS'(1) << pick : '0;
    exec_d = grant && |pick_mask;
    wdog_d = state_q == ISSUE && |mask_q ? WD'(1) : state_q == WAIT && !to_done ? wdog_q + WD'(1) : '0;
    done_d = to_done;
    done_warp_d = to_done ? id_q : done_warp_q;
    tmo_d = tmo_q || fin_to;
    rr_d = state_q == DONE ? (id_q == WID'(NUM_WARPS - 1) ? '0 : id_q + WID'(1)) : rr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      id_q <= '0;
      inst_q <= '0;
      mask_q <= '0;
      ack_q <= '0;
      exec_q <= 1'b0;
      wdog_q <= '0;
      done_q <= 1'b0;
      done_warp_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      id_q <= id_d;
      inst_q <= inst_d;
      mask_q <= mask_d;
      ack_q <= ack_d;
      exec_q <= exec_d;
      wdog_q <= wdog_d;
      done_q <= done_d;
      done_warp_q <= done_warp_d;
      tmo_q <= tmo_d;
    end
  end
  assign warp_ack = ack_q;
  assign la_execute = exec_q;
  assign la_instruction = inst_q;
  assign la_lane_enable = mask_q;
  assign done_valid = done_q;
  assign done_warp = done_warp_q;
  assign timeout_err = tmo_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_warp_issue_scheduler.sv
// tb_warp_issue_scheduler: scoreboarded random and directed checks of warp_issue_scheduler
module tb_warp_issue_scheduler;
  localparam int NW = 4;
  localparam int NL = 4;
  localparam int TO = 16;
  typedef struct {
    int w;
    logic [31:0] inst;
    logic [3:0] mask;
    int lat;
    int delta;
    logic tmo;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NW-1:0] warp_valid;
  logic [32*NW-1:0] warp_inst = '0;
  logic [NL*NW-1:0] warp_mask = '0;
  logic [NW-1:0] warp_ack;
  logic la_execute;
  logic [31:0] la_instruction;
  logic [NL-1:0] la_lane_enable;
  logic la_ready = 1'b1;
  logic done_valid;
  logic [1:0] done_warp;
  logic timeout_err;
  logic busy;
  exp_t exp_q[$];
  exp_t cur;
  logic [31:0] inst_r[NW];
  logic [3:0] mask_r[NW];
  int lat_r[NW];
  int ack_cnt[NW] = '{default: 0};
  int base[NW] = '{default: 0};
  logic [NW-1:0] vreq = '0;
  bit cont = 1'b0;
  int acks_total = 0;
  int stop_at = 0;
  int rd = 0;
  int ret = 0;
  int rem = 0;
  int ack_cyc = 0;
  bit have = 1'b0;
  int cyc = 0;
  int rr = 0;
  bit sticky = 1'b0;
  int errors = 0;
  int checks = 0;
  warp_issue_scheduler #(.NUM_WARPS(NW), .NUM_LANES(NL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .warp_valid(warp_valid), .warp_inst(warp_inst), .warp_mask(warp_mask),
    .warp_ack(warp_ack), .la_execute(la_execute), .la_instruction(la_instruction),
    .la_lane_enable(la_lane_enable), .la_ready(la_ready), .done_valid(done_valid),
    .done_warp(done_warp), .timeout_err(timeout_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb begin
    for (int w = 0; w < NW; w++)
      warp_valid[w] = vreq[w] && acks_total < stop_at && (cont || ack_cnt[w] == base[w]);
  end
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask
  task automatic push(input int w);
    exp_t e;
    bit t;
    t = mask_r[w] != 0 && lat_r[w] > TO;
    sticky = sticky || t;
    e.w = w;
    e.inst = inst_r[w];
    e.mask = mask_r[w];
    e.lat = lat_r[w];
    e.delta = mask_r[w] == 0 ? 1 : t ? TO + 1 : (lat_r[w] < 2 ? 2 : lat_r[w]) + 1;
    e.tmo = sticky;
    exp_q.push_back(e);
  endtask
  task automatic plan(input logic [NW-1:0] vm, input int ngr);
    int last;
    last = -1;
    for (int k = 0; k < (ngr > 0 ? ngr : NW); k++) begin
      if (ngr > 0 || vm[(rr + k) % NW]) begin
        last = (rr + k) % NW;
        push(last);
      end
    end
    if (last >= 0) rr = (last + 1) % NW;
    for (int w = 0; w < NW; w++) begin
      warp_inst[32*w +: 32] = inst_r[w];
      warp_mask[NL*w +: NL] = mask_r[w];
      base[w] = ack_cnt[w];
    end
    cont = ngr > 0;
    stop_at = acks_total + (ngr > 0 ? ngr : 1 << 30);
  endtask
  task automatic go(input logic [NW-1:0] vm, input int ngr);
    int n;
    plan(vm, ngr);
    vreq = vm;
    n = 0;
    while ((ret != exp_q.size() || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("completion", ret, exp_q.size());
    vreq = '0;
    @(negedge clk);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, " ack"}, warp_ack, 0);
    chk({nm, " exec"}, la_execute, 0);
    chk({nm, " inst"}, la_instruction, 0);
    chk({nm, " mask"}, la_lane_enable, 0);
    chk({nm, " done"}, done_valid, 0);
    chk({nm, " done_warp"}, done_warp, 0);
    chk({nm, " tmo"}, timeout_err, 0);
    chk({nm, " busy"}, busy, 0);
  endtask
  task automatic rnd();
    for (int w = 0; w < NW; w++) begin
      inst_r[w] = $urandom;
      mask_r[w] = $urandom_range(0, 5) == 0 ? 4'h0 : 4'($urandom_range(1, 15));
      lat_r[w] = $urandom_range(0, 9) == 0 ? 20 : $urandom_range(1, 12);
    end
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        rd = exp_q.size();
        ret = rd;
        have = 1'b0;
        la_ready = 1'b1;
        rem = 0;
      end else begin
        if (rem > 0) begin
          rem--;
          if (rem == 0) la_ready = 1'b1;
        end
        if (warp_ack != 0) begin
          if (rd >= exp_q.size()) begin
            chk("unexpected ack", warp_ack, 0);
          end else begin
            cur = exp_q[rd];
            rd++;
            have = 1'b1;
            ack_cyc = cyc;
            ack_cnt[cur.w]++;
            acks_total++;
            chk("ack", warp_ack, 64'(1) << cur.w);
            chk("exec", la_execute, cur.mask != 0);
            if (la_execute) begin
              chk("la_instruction", la_instruction, cur.inst);
              chk("la_lane_enable", la_lane_enable, cur.mask);
              la_ready = 1'b0;
              rem = cur.lat;
            end
          end
        end else if (la_execute) begin
          chk("stray exec", la_execute, 0);
        end
        if (done_valid) begin
          if (!have) begin
            chk("unexpected done", done_valid, 0);
          end else begin
            chk("done_warp", done_warp, cur.w);
            chk("done latency", cyc - ack_cyc, cur.delta);
            chk("timeout_err", timeout_err, cur.tmo);
            ret++;
            have = 1'b0;
            la_ready = 1'b1;
            rem = 0;
          end
        end
      end
    end
  end
  initial begin
    int n;
    for (int w = 0; w < NW; w++) begin
      inst_r[w] = 32'h1000_0000 * (w + 1) + 32'h55;
      mask_r[w] = 4'hF;
      lat_r[w] = 1 + w;
    end
    repeat (3) begin
      @(negedge clk);
      chk_zero("reset");
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("idle busy", busy, 0);
      chk("idle ack", warp_ack, 0);
    end
    go(4'hF, 6);
    inst_r[2] = 32'h1A2B3C4D;
    mask_r[2] = 4'b1111;
    lat_r[2] = 3;
    go(4'b0100, 0);
    mask_r[1] = 4'b0000;
    go(4'b0010, 0);
    mask_r[3] = 4'b1010;
    lat_r[3] = TO;
    go(4'b1000, 0);
    lat_r[3] = 1;
    go(4'b1000, 0);
    mask_r[0] = 4'b0110;
    lat_r[0] = 1000;
    go(4'b0001, 0);
    lat_r[0] = 2;
    go(4'b0001, 0);
    for (int it = 0; it < 30; it++) begin
      rnd();
      if ($urandom_range(0, 3) == 0) go(4'hF, $urandom_range(2, 7));
      else go(4'($urandom_range(1, 15)), 0);
    end
    mask_r[2] = 4'b0011;
    lat_r[2] = 1000;
    plan(4'b0100, 0);
    vreq = 4'b0100;
    n = 0;
    while (warp_ack == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid-wait grant seen", warp_ack, 4'b0100);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    vreq = '0;
    @(negedge clk);
    chk_zero("reset mid-wait");
    @(negedge clk);
    rst = 1'b0;
    rr = 0;
    sticky = 1'b0;
    rnd();
    go(4'b1101, 0);
    chk("all retired", ret, exp_q.size());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
